serial_port_router: RTL and testbench

SERIAL_PORT_ROUTER -- requirements
Module: serial_port_router

---
 rtl/serial_port_router_pkg.sv | 36 +++
 rtl/ssd_hex_decoder.sv | 33 +++
 rtl/serial_port_router.sv | 133 +++++++++++++
 tb/tb_serial_port_router.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_port_router_pkg.sv
// Shared types and constants for the serial port router.
// Holds the FSM states, seven-segment codes and address-width helper.
package serial_port_router_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_PAR,
    S_DONE
  } state_t;

  // Active-high segment codes, bit0 = segment a
  localparam logic [6:0] SSD_0 = 7'h3F;
  localparam logic [6:0] SSD_1 = 7'h06;
  localparam logic [6:0] SSD_2 = 7'h5B;
  localparam logic [6:0] SSD_3 = 7'h4F;
  localparam logic [6:0] SSD_4 = 7'h66;
  localparam logic [6:0] SSD_5 = 7'h6D;
  localparam logic [6:0] SSD_6 = 7'h7D;
  localparam logic [6:0] SSD_7 = 7'h07;
  localparam logic [6:0] SSD_8 = 7'h7F;
  localparam logic [6:0] SSD_9 = 7'h6F;
  localparam logic [6:0] SSD_A = 7'h77;
  localparam logic [6:0] SSD_B = 7'h7C;
  localparam logic [6:0] SSD_C = 7'h39;
  localparam logic [6:0] SSD_D = 7'h5E;
  localparam logic [6:0] SSD_E = 7'h79;
  localparam logic [6:0] SSD_F = 7'h71;

  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Hex digit to seven-segment code lookup.
// Pure combinational table.
module ssd_hex_decoder
  import serial_port_router_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SSD_0;
    unique case (hex)
      4'h0: seg = SSD_0;
      4'h1: seg = SSD_1;
      4'h2: seg = SSD_2;
      4'h3: seg = SSD_3;
      4'h4: seg = SSD_4;
      4'h5: seg = SSD_5;
      4'h6: seg = SSD_6;
      4'h7: seg = SSD_7;
      4'h8: seg = SSD_8;
      4'h9: seg = SSD_9;
      4'hA: seg = SSD_A;
      4'hB: seg = SSD_B;
      4'hC: seg = SSD_C;
      4'hD: seg = SSD_D;
      4'hE: seg = SSD_E;
      4'hF: seg = SSD_F;
      default: seg = SSD_0;
    endcase
  end

endmodule

// File: rtl/serial_port_router.sv
// Serial frame receiver that forwards data bits to one of
// NUM_PORTS outputs selected by the frame's address field.
module serial_port_router
  import serial_port_router_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int LEN_W     = 4,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clkEn,
  input  logic                 SerIn,
  output logic                 SerOut,
  output logic                 SerOutValid,
  output logic [NUM_PORTS-1:0] PortSel,
  output logic                 Done,
  output logic                 FrameErr,
  output logic [6:0]           SSD_Out
);

  localparam int ADDR_W = addr_width(NUM_PORTS);
  localparam state_t TAIL = PARITY_EN ? S_PAR : S_DONE;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nx;
  logic [LEN_W-1:0]  len_sr;
  logic [LEN_W-1:0]  len_nx;
  logic [LEN_W-1:0]  cnt;
  logic [1:0]        bit_cnt;
  logic              par_acc;
  logic              err;
  logic              addr_last;
  logic              len_last;
  logic              cnt_last;
  logic              addr_ok;
  logic              addr_nx_ok;
  logic [3:0]        cnt_hex;

  assign addr_nx    = ADDR_W'({addr, SerIn});
  assign len_nx     = LEN_W'({len_sr, SerIn});
  assign addr_last  = (bit_cnt == 2'(ADDR_W - 1));
  assign len_last   = (bit_cnt == 2'(LEN_W - 1));
  assign cnt_last   = (cnt == LEN_W'(1));
  assign addr_ok    = (int'(addr) < NUM_PORTS);
  assign addr_nx_ok = (int'(addr_nx) < NUM_PORTS);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (clkEn && !SerIn) state_nx = S_ADDR;
      S_ADDR: if (clkEn && addr_last) state_nx = S_LEN;
      S_LEN: begin
        if (clkEn && len_last)
          state_nx = (len_nx == '0) ? TAIL : S_DATA;
      end
      S_DATA: if (clkEn && cnt_last) state_nx = TAIL;
      S_PAR:  if (clkEn) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // DONE is left unconditionally, so it clears cnt even without clkEn
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr    <= '0;
      len_sr  <= '0;
      cnt     <= '0;
      bit_cnt <= '0;
      par_acc <= 1'b0;
      err     <= 1'b0;
    end else if (state == S_DONE) begin
      cnt <= '0;
    end else if (clkEn) begin
      unique case (state)
        S_IDLE: begin
          if (!SerIn) begin
            err     <= 1'b0;
            bit_cnt <= '0;
            par_acc <= 1'b0;
          end
        end
        S_ADDR: begin
          addr    <= addr_nx;
          bit_cnt <= addr_last ? 2'd0 : bit_cnt + 2'd1;
          if (addr_last && !addr_nx_ok) err <= 1'b1;
        end
        S_LEN: begin
          len_sr  <= len_nx;
          bit_cnt <= bit_cnt + 2'd1;
          if (len_last) cnt <= len_nx;
        end
        S_DATA: begin
          cnt     <= cnt - LEN_W'(1);
          par_acc <= par_acc ^ SerIn;
        end
        S_PAR: begin
          if (par_acc ^ SerIn) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    SerOut      = 1'b0;
    SerOutValid = 1'b0;
    PortSel     = '0;
    if (state == S_DATA && clkEn && addr_ok) begin
      SerOut      = SerIn;
      SerOutValid = 1'b1;
      PortSel     = NUM_PORTS'(1) << addr;
    end
  end

  assign Done     = (state == S_DONE);
  assign FrameErr = err;
  assign cnt_hex  = 4'(cnt);

  ssd_hex_decoder u_ssd (
    .hex (cnt_hex),
    .seg (SSD_Out)
  );

endmodule

// File: tb/tb_serial_port_router.sv
// Directed bench for serial_port_router: default, 3-port
// and parity-enabled instances driven from separate serial lines.
module tb_serial_port_router;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [2:0] si  = 3'b111;

  logic       so_a, v_a, dn_a, fe_a;
  logic [3:0] ps_a;
  logic [6:0] ssd_a;
  logic       so_b, v_b, dn_b, fe_b;
  logic [2:0] ps_b;
  logic [6:0] ssd_b;
  logic       so_c, v_c, dn_c, fe_c;
  logic [3:0] ps_c;
  logic [6:0] ssd_c;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  serial_port_router u_a (
    .clk(clk), .rst(rst), .clkEn(en), .SerIn(si[0]),
    .SerOut(so_a), .SerOutValid(v_a), .PortSel(ps_a),
    .Done(dn_a), .FrameErr(fe_a), .SSD_Out(ssd_a)
  );

  serial_port_router #(.NUM_PORTS(3)) u_b (
    .clk(clk), .rst(rst), .clkEn(en), .SerIn(si[1]),
    .SerOut(so_b), .SerOutValid(v_b), .PortSel(ps_b),
    .Done(dn_b), .FrameErr(fe_b), .SSD_Out(ssd_b)
  );

  serial_port_router #(.PARITY_EN(1'b1)) u_c (
    .clk(clk), .rst(rst), .clkEn(en), .SerIn(si[2]),
    .SerOut(so_c), .SerOutValid(v_c), .PortSel(ps_c),
    .Done(dn_c), .FrameErr(fe_c), .SSD_Out(ssd_c)
  );

  typedef struct {
    logic       en;
    logic       si;
    logic       v;
    logic       so;
    logic [3:0] ps;
    logic [6:0] ssd;
    logic       dn;
    logic       fe;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic void add(input logic e, input logic s,
                              input logic v, input logic so,
                              input logic [3:0] ps,
                              input logic [6:0] ssd,
                              input logic dn, input logic fe);
    vec_t t;
    t.en = e; t.si = s; t.v = v; t.so = so;
    t.ps = ps; t.ssd = ssd; t.dn = dn; t.fe = fe;
    vq.push_back(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int sel, input logic e, input logic b);
    en = e;
    si = 3'b111;
    si[sel] = b;
  endtask

  task automatic send(input int sel, input logic [15:0] bits,
                      input int n);
    for (int k = n - 1; k >= 0; k--) begin
      put(sel, 1'b1, bits[k]);
      tick();
    end
  endtask

  task automatic run_vecs(input string tag);
    foreach (vq[i]) begin
      en = vq[i].en;
      si = {2'b11, vq[i].si};
      @(negedge clk);
      chk($sformatf("%s[%0d]", tag, i),
          {v_a, so_a, ps_a, ssd_a, dn_a, fe_a},
          {vq[i].v, vq[i].so, vq[i].ps, vq[i].ssd,
           vq[i].dn, vq[i].fe});
      tick();
    end
    vq.delete();
  endtask

  initial begin
    tick();
    tick();
    @(negedge clk);
    chk("rst_a", {v_a, so_a, ps_a, ssd_a, dn_a, fe_a},
        {2'b00, 4'h0, 7'h3F, 2'b00});
    chk("rst_b", {v_b, so_b, ps_b, ssd_b, dn_b, fe_b},
        {2'b00, 3'h0, 7'h3F, 2'b00});
    chk("rst_c", {v_c, so_c, ps_c, ssd_c, dn_c, fe_c},
        {2'b00, 4'h0, 7'h3F, 2'b00});
    rst = 1'b1;
    put(0, 1'b1, 1'b1);
    tick();

    // start 0, addr 11, len 0010, data 1,0
    add(1, 0, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(1, 1, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(1, 1, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(1, 0, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(1, 0, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(1, 1, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(1, 0, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(1, 1, 1, 1, 4'h8, 7'h5B, 0, 0);
    add(1, 0, 1, 0, 4'h8, 7'h06, 0, 0);
    add(1, 1, 0, 0, 4'h0, 7'h3F, 1, 0);
    add(1, 1, 0, 0, 4'h0, 7'h3F, 0, 0);
    run_vecs("base");

    // same frame, clkEn toggling 1,0
    add(1, 0, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(0, 1, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(1, 1, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(0, 1, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(1, 1, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(0, 1, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(1, 0, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(0, 1, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(1, 0, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(0, 1, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(1, 1, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(0, 1, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(1, 0, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(0, 1, 0, 0, 4'h0, 7'h5B, 0, 0);
    add(1, 1, 1, 1, 4'h8, 7'h5B, 0, 0);
    add(0, 1, 0, 0, 4'h0, 7'h06, 0, 0);
    add(1, 0, 1, 0, 4'h8, 7'h06, 0, 0);
    add(0, 1, 0, 0, 4'h0, 7'h3F, 1, 0);
    add(1, 1, 0, 0, 4'h0, 7'h3F, 0, 0);
    add(0, 1, 0, 0, 4'h0, 7'h3F, 0, 0);
    run_vecs("toggle");

    // NUM_PORTS=3, address 11 is out of range
    send(1, 16'b0_11_0001, 7);
    put(1, 1'b1, 1'b1);
    @(negedge clk);
    chk("p3_bad_data", {v_b, so_b, ps_b, fe_b, ssd_b},
        {2'b00, 3'b000, 1'b1, 7'h06});
    tick();
    put(1, 1'b1, 1'b1);
    @(negedge clk);
    chk("p3_bad_done", {dn_b, fe_b, v_b}, 3'b110);
    tick();
    send(1, 16'b0_10_0001, 7);
    put(1, 1'b1, 1'b0);
    @(negedge clk);
    chk("p3_good_data", {v_b, so_b, ps_b, fe_b}, {2'b10, 3'b100, 1'b0});
    tick();
    put(1, 1'b1, 1'b1);
    @(negedge clk);
    chk("p3_good_done", {dn_b, fe_b}, 2'b10);
    tick();

    // parity: data 1,1 with parity 0 then parity 1
    send(2, 16'b0_01_0010, 7);
    put(2, 1'b1, 1'b1);
    @(negedge clk);
    chk("par_data", {v_c, so_c, ps_c}, {2'b11, 4'b0010});
    tick();
    put(2, 1'b1, 1'b1);
    tick();
    put(2, 1'b1, 1'b0);
    @(negedge clk);
    chk("par_state", {v_c, ps_c, dn_c}, 6'b0);
    tick();
    put(2, 1'b1, 1'b1);
    @(negedge clk);
    chk("par_ok", {dn_c, fe_c}, 2'b10);
    tick();
    send(2, 16'b0_01_0010_11, 9);
    put(2, 1'b1, 1'b1);
    tick();
    put(2, 1'b1, 1'b1);
    @(negedge clk);
    chk("par_bad", {dn_c, fe_c}, 2'b11);
    tick();
    @(negedge clk);
    chk("par_sticky", {dn_c, fe_c}, 2'b01);
    tick();
    put(2, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    chk("par_clear", fe_c, 1'b0);
    send(2, 16'b01_0000, 6);
    put(2, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    chk("par_n0_done", {dn_c, fe_c, v_c}, 3'b100);
    tick();

    // N=0 without parity: Done right after last LEN bit
    send(0, 16'b0_10_0000, 7);
    put(0, 1'b1, 1'b1);
    @(negedge clk);
    chk("n0_done", {v_a, dn_a, ssd_a}, {2'b01, 7'h3F});
    tick();
    @(negedge clk);
    chk("n0_idle", {v_a, dn_a}, 2'b00);

    // reset in DATA with cnt=5
    send(0, 16'b0_00_0101, 7);
    put(0, 1'b1, 1'b1);
    @(negedge clk);
    chk("rd_data", {v_a, so_a, ps_a, ssd_a}, {2'b11, 4'h1, 7'h6D});
    rst = 1'b0;
    tick();
    rst = 1'b1;
    put(0, 1'b1, 1'b1);
    @(negedge clk);
    chk("rd_after", {v_a, ps_a, ssd_a, dn_a}, {1'b0, 4'h0, 7'h3F, 1'b0});
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk($sformatf("rd_nodone%0d", k), {dn_a, ssd_a}, {1'b0, 7'h3F});
    end
    tick();
    send(0, 16'b0_01_0001, 7);
    put(0, 1'b1, 1'b1);
    @(negedge clk);
    chk("rd_next_data", {v_a, so_a, ps_a, ssd_a}, {2'b11, 4'h2, 7'h06});
    tick();
    @(negedge clk);
    chk("rd_next_done", {dn_a, fe_a}, 2'b10);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
